// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, state encoding and funct decode for alu_sequencer
// Purpose: funct codes, FSM state type and default datapath width used by
//          alu_sequencer and mul_shift_add.
// Ports:   none (package).
// Option:  ALU_SEQ_EARLY_TERM_EN (consumed by mul_shift_add / alu_sequencer).
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Codes forwarded unchanged to the external combinational ALU.
  function automatic logic is_alu_funct(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) ||
           (f == F_SUB) || (f == F_SLT);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - iterative unsigned shift-add multiplier datapath
// Purpose: product/multiplicand/counter registers for MULTU, one iteration per step.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          load            - capture operands, clear iteration counter
//          step            - perform one add/shift iteration
//          multiplicand_i  - operand A
//          multiplier_i    - operand B
//          last_o          - the current step is the final one
//          hi_o, lo_o      - product halves as they will be after the current step
// Option:  ALU_SEQ_EARLY_TERM_EN - stop once remaining multiplier bits are zero.
module mul_shift_add
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_out;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;

  // Carry out of the upper-half add becomes the new top bit after the shift.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_EARLY_TERM_EN
  // Shadow of the multiplier bits not yet consumed (bit 0 is consumed on this step).
  logic [WIDTH-2:0] mrem_q;
  logic [CW-1:0]    shamt;

  always_comb begin
    shamt    = LAST_CNT - cnt_q;
    last_o   = (mrem_q == '0) || (cnt_q == LAST_CNT);
    // Remaining iterations would add nothing, so a single shift finishes them.
    prod_out = prod_step >> shamt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mrem_q <= '0;
    end else if (load) begin
      mrem_q <= multiplier_i[WIDTH-1:1];
    end else if (step) begin
      mrem_q <= mrem_q >> 1;
    end
  end
`else
  always_comb begin
    last_o   = (cnt_q == LAST_CNT);
    prod_out = prod_step;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      prod_q  <= {{WIDTH{1'b0}}, multiplier_i};
      mcand_q <= multiplicand_i;
      cnt_q   <= '0;
    end else if (step) begin
      prod_q  <= prod_step;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign hi_o = prod_out[2*WIDTH-1:WIDTH];
  assign lo_o = prod_out[WIDTH-1:0];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues ops to the combinational ALU and runs MULTU/MFHI/MFLO
// Purpose: start/ready request port, registered ALU drive, result capture, HI/LO.
// Ports:   clk, reset           - clock, synchronous active-high reset
//          start, ready         - request valid / sequencer idle
//          funct, dataA, dataB  - operation code and operands
//          dataOut, done, err   - registered result, completion pulse, unknown-funct flag
//          aluA, aluB, aluSignal- registered ALU operand/op drive
//          aluOut               - combinational ALU result
// Option:  ALU_SEQ_EARLY_TERM_EN - MULTU finishes early on small multipliers.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [5:0]       aluSignal,
  input  logic [WIDTH-1:0] aluOut
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [5:0]       alu_signal_q;
  logic             err_q;

  logic             accept;
  logic             is_alu;
  logic             is_multu;
  logic             mul_skip;
  logic             mul_last;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign accept   = (state_q == IDLE) && start;
  assign is_alu   = is_alu_funct(funct);
  assign is_multu = (funct == F_MULTU);

`ifdef ALU_SEQ_EARLY_TERM_EN
  // A zero multiplier has nothing to iterate over: answer straight from IDLE.
  assign mul_skip = (dataB == '0);
`else
  assign mul_skip = 1'b0;
`endif

  mul_shift_add #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk            (clk),
    .reset          (reset),
    .load           (accept && is_multu),
    .step           (state_q == MUL),
    .multiplicand_i (dataA),
    .multiplier_i   (dataB),
    .last_o         (mul_last),
    .hi_o           (mul_hi),
    .lo_o           (mul_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_alu) begin
            state_d = ALU;
          end else if (is_multu && !mul_skip) begin
            state_d = MUL;
          end else begin
            state_d = DONE;
          end
        end
      end
      ALU:     state_d = DONE;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  // Result, HI/LO and err only change on the edge that enters DONE, so a reset
  // mid-operation never leaves a partial update behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_signal_q <= F_ADD;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_alu) begin
              alu_a_q      <= dataA;
              alu_b_q      <= dataB;
              alu_signal_q <= funct;
            end else if (is_multu) begin
              if (mul_skip) begin
                hi_q       <= '0;
                lo_q       <= '0;
                data_out_q <= '0;
                err_q      <= 1'b0;
              end
            end else if (funct == F_MFHI) begin
              data_out_q <= hi_q;
              err_q      <= 1'b0;
            end else if (funct == F_MFLO) begin
              data_out_q <= lo_q;
              err_q      <= 1'b0;
            end else begin
              data_out_q <= '0;
              err_q      <= 1'b1;
            end
          end
        end
        ALU: begin
          data_out_q <= aluOut;
          err_q      <= 1'b0;
        end
        MUL: begin
          if (mul_last) begin
            hi_q       <= mul_hi;
            lo_q       <= mul_lo;
            data_out_q <= mul_lo;
            err_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dataOut   = data_out_q;
  assign err       = err_q;
  assign aluA      = alu_a_q;
  assign aluB      = alu_b_q;
  assign aluSignal = alu_signal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
// Purpose: drives ops through the start/ready port with a behavioural ALU attached.
// Option:  ALU_SEQ_EARLY_TERM_EN selects the early-termination MULTU latencies.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 32;

`ifdef ALU_SEQ_EARLY_TERM_EN
  localparam int LAT_6X1    = 2;
  localparam int LAT_BZERO  = 1;
  localparam int LAT_30000  = 19;
  localparam int LAT_7X9    = 5;
`else
  localparam int LAT_6X1    = 33;
  localparam int LAT_BZERO  = 33;
  localparam int LAT_30000  = 33;
  localparam int LAT_7X9    = 33;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         ready;
  logic [5:0]   funct;
  logic [W-1:0] dataA, dataB;
  logic [W-1:0] dataOut;
  logic         done;
  logic         err;
  logic [W-1:0] aluA, aluB;
  logic [5:0]   aluSignal;
  logic [W-1:0] aluOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (aluSignal)
      F_AND:   aluOut = aluA & aluB;
      F_OR:    aluOut = aluA | aluB;
      F_ADD:   aluOut = aluA + aluB;
      F_SUB:   aluOut = aluA - aluB;
      F_SLT:   aluOut = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
      default: aluOut = '0;
    endcase
  end

  alu_sequencer #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ready     (ready),
    .funct     (funct),
    .dataA     (dataA),
    .dataB     (dataB),
    .dataOut   (dataOut),
    .done      (done),
    .err       (err),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluSignal (aluSignal),
    .aluOut    (aluOut)
  );

  // Issue one op from an idle sequencer; returns the edge count at which done
  // was first seen high (0 on timeout) and whether ready stayed low meanwhile.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit rdy_ok);
    @(negedge clk);
    start = 1'b1; funct = f; dataA = a; dataB = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    rdy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL timeout funct=%b got no done within 100 cycles", f);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct = '0; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dataOut got %h exp 0", dataOut); end
    checks++; if (aluA !== 32'h0 || aluB !== 32'h0) begin errors++; $display("FAIL reset_aluAB got %h %h exp 0 0", aluA, aluB); end
    checks++; if (aluSignal !== 6'b100000) begin errors++; $display("FAIL reset_aluSignal got %b exp 100000", aluSignal); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk);
    start = 1'b1; funct = F_ADD; dataA = 32'd5; dataB = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; funct = '0; dataA = '0; dataB = '0;
    @(negedge clk);
    checks++; if (aluSignal !== 6'b100000) begin errors++; $display("FAIL add_aluSignal got %b exp 100000", aluSignal); end
    checks++; if (aluA !== 32'd5 || aluB !== 32'd7) begin errors++; $display("FAIL add_aluAB got %0d %0d exp 5 7", aluA, aluB); end
    checks++; if (done !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL add_alu_cycle got done=%b ready=%b exp 0 0", done, ready); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_latency got done=%b exp 1 at cycle 2", done); end
    checks++; if (dataOut !== 32'd12) begin errors++; $display("FAIL add_dataOut got %h exp 0000000c", dataOut); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", err); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL add_after got done=%b ready=%b exp 0 1", done, ready); end
  endtask

  task automatic test_sub_slt();
    int lat; bit rdy_ok;
    issue(F_SUB, 32'd3, 32'd5, lat, rdy_ok);
    checks++; if (lat != 2) begin errors++; $display("FAIL sub_latency got %0d exp 2", lat); end
    checks++; if (dataOut !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_dataOut got %h exp fffffffe", dataOut); end
    checks++; if (!rdy_ok) begin errors++; $display("FAIL sub_ready got high exp low while busy"); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sub_pulse got done=%b exp 0", done); end
    issue(F_SLT, 32'd3, 32'd5, lat, rdy_ok);
    checks++; if (lat != 2) begin errors++; $display("FAIL slt_latency got %0d exp 2", lat); end
    checks++; if (dataOut !== 32'd1) begin errors++; $display("FAIL slt_dataOut got %h exp 00000001", dataOut); end
    checks++; if (!rdy_ok) begin errors++; $display("FAIL slt_ready got high exp low while busy"); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL slt_pulse got done=%b exp 0", done); end
  endtask

  task automatic test_logic();
    int lat; bit rdy_ok;
    issue(F_AND, 32'hF0F0F0F0, 32'h0FF00FF0, lat, rdy_ok);
    checks++; if (dataOut !== 32'h00F000F0) begin errors++; $display("FAIL and_dataOut got %h exp 00f000f0", dataOut); end
    issue(F_OR, 32'hF0F0F0F0, 32'h0FF00FF0, lat, rdy_ok);
    checks++; if (dataOut !== 32'hFFF0FFF0) begin errors++; $display("FAIL or_dataOut got %h exp fff0fff0", dataOut); end
    issue(F_MFLO, 32'h12345678, 32'h9ABCDEF0, lat, rdy_ok);
    checks++; if (aluSignal !== F_OR || aluA !== 32'hF0F0F0F0) begin errors++; $display("FAIL alu_hold got %b %h exp 100101 f0f0f0f0", aluSignal, aluA); end
  endtask

  task automatic test_start_during_mul();
    int lat; int ndone;
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; dataA = 32'd7; dataB = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; ndone = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b1; funct = F_MFHI; dataA = '0; dataB = '0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = i;
      end
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d exp 1", ndone); end
    checks++; if (lat != LAT_7X9) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", lat, LAT_7X9); end
    checks++; if (dataOut !== 32'd63) begin errors++; $display("FAIL busy_start_dataOut got %h exp 0000003f", dataOut); end
  endtask

  task automatic test_early_term();
    int lat; bit rdy_ok;
    issue(F_MULTU, 32'd6, 32'd1, lat, rdy_ok);
    checks++; if (lat != LAT_6X1) begin errors++; $display("FAIL mul6x1_latency got %0d exp %0d", lat, LAT_6X1); end
    checks++; if (dataOut !== 32'd6) begin errors++; $display("FAIL mul6x1_lo got %h exp 00000006", dataOut); end
    issue(F_MFHI, '0, '0, lat, rdy_ok);
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL mul6x1_hi got %h exp 0", dataOut); end
    issue(F_MULTU, 32'd1234, 32'd0, lat, rdy_ok);
    checks++; if (lat != LAT_BZERO) begin errors++; $display("FAIL mulb0_latency got %0d exp %0d", lat, LAT_BZERO); end
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL mulb0_lo got %h exp 0", dataOut); end
    issue(F_MULTU, 32'h00010000, 32'h00030000, lat, rdy_ok);
    checks++; if (lat != LAT_30000) begin errors++; $display("FAIL mul30000_latency got %0d exp %0d", lat, LAT_30000); end
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL mul30000_lo got %h exp 0", dataOut); end
    issue(F_MFHI, '0, '0, lat, rdy_ok);
    checks++; if (dataOut !== 32'd3) begin errors++; $display("FAIL mul30000_hi got %h exp 00000003", dataOut); end
  endtask

  task automatic test_multu();
    int lat; bit rdy_ok;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rdy_ok);
    checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", lat); end
    checks++; if (dataOut !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", dataOut); end
    checks++; if (!rdy_ok) begin errors++; $display("FAIL multu_ready got high exp low while busy"); end
    issue(F_MFHI, '0, '0, lat, rdy_ok);
    checks++; if (lat != 1) begin errors++; $display("FAIL mfhi_latency got %0d exp 1", lat); end
    checks++; if (dataOut !== 32'hFFFFFFFE) begin errors++; $display("FAIL mfhi_dataOut got %h exp fffffffe", dataOut); end
    issue(F_MFLO, '0, '0, lat, rdy_ok);
    checks++; if (dataOut !== 32'h00000001) begin errors++; $display("FAIL mflo_dataOut got %h exp 00000001", dataOut); end
  endtask

  task automatic test_unknown();
    int lat; bit rdy_ok;
    issue(6'b111111, 32'hDEADBEEF, 32'h1, lat, rdy_ok);
    checks++; if (lat != 1) begin errors++; $display("FAIL unknown_latency got %0d exp 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unknown_err got %b exp 1", err); end
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL unknown_dataOut got %h exp 0", dataOut); end
    issue(F_ADD, 32'd1, 32'd1, lat, rdy_ok);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL unknown_clear_err got %b exp 0", err); end
    checks++; if (dataOut !== 32'd2) begin errors++; $display("FAIL unknown_next_dataOut got %h exp 00000002", dataOut); end
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rdy_ok; int ndone;
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done); end
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL midreset_dataOut got %h exp 0", dataOut); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midreset_stray_done got %0d exp 0", ndone); end
    issue(F_MFHI, '0, '0, lat, rdy_ok);
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL midreset_hi got %h exp 0", dataOut); end
    issue(F_MFLO, '0, '0, lat, rdy_ok);
    checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL midreset_lo got %h exp 0", dataOut); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_start_during_mul();
    test_early_term();
    test_multu();
    test_unknown();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion within 2 ms of simulated time");
    $fatal(1);
  end

endmodule
